// File: rtl/clock_pkg.sv
// Shared definitions for the clock, chime and display blocks: mode encoding,
// the BCD digit type and the per-field tens/units limits.
package clock_pkg;

    typedef logic [3:0] digit_t;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2
    } mode_e;

    localparam digit_t SEC_MAX_TENS   = 4'd5;
    localparam digit_t SEC_MAX_UNITS  = 4'd9;
    localparam digit_t MIN_MAX_TENS   = 4'd5;
    localparam digit_t MIN_MAX_UNITS  = 4'd9;
    localparam digit_t HOUR_MAX_TENS  = 4'd2;
    localparam digit_t HOUR_MAX_UNITS = 4'd3;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps to 00 after TENS_MAX/UNITS_MAX. The digits are
// kept as a tens/units pair so no binary-to-BCD conversion is ever needed.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter digit_t TENS_MAX  = 4'd5,
    parameter digit_t UNITS_MAX = 4'd9
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   inc,
    input  logic   clr,
    output digit_t tens,
    output digit_t units,
    output logic   carry
);

    digit_t tens_q, tens_d;
    digit_t units_q, units_d;
    logic   at_limit;

    assign at_limit = (tens_q == TENS_MAX) && (units_q == UNITS_MAX);
    // Combinational so a full ripple through all three fields lands in one cycle.
    assign carry    = inc && at_limit;

    always_comb begin
        tens_d  = tens_q;
        units_d = units_q;
        if (clr) begin
            tens_d  = '0;
            units_d = '0;
        end else if (inc) begin
            if (at_limit) begin
                tens_d  = '0;
                units_d = '0;
            end else if (units_q == 4'd9) begin
                tens_d  = tens_q + 4'd1;
                units_d = '0;
            end else begin
                units_d = units_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tens_q  <= '0;
            units_q <= '0;
        end else begin
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

    assign tens  = tens_q;
    assign units = units_q;

endmodule

// File: rtl/bcd_time_counter.sv
// 24-hour hh:mm:ss BCD clock with a 1 Hz prescaler and a button-driven
// RUN -> SET_HOUR -> SET_MIN -> RUN set mode.
module bcd_time_counter
    import clock_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output digit_t     Hour_First,
    output digit_t     Hour_Second,
    output digit_t     Minute_First,
    output digit_t     Minute_Second,
    output digit_t     Second_First,
    output digit_t     Second_Second,
    output logic       tick_1hz,
    output logic [1:0] setting
);

    localparam int             PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] TC = PW'(CLK_HZ - 1);

    mode_e         mode_q, mode_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic          inc_ok, sec_clr, min_inc, hour_inc;
    logic          sec_carry, min_carry, hour_carry_unused;

    always_comb begin
        mode_d = mode_q;
        if (btn_mode) begin
            case (mode_q)
                MODE_RUN:      mode_d = MODE_SET_HOUR;
                MODE_SET_HOUR: mode_d = MODE_SET_MIN;
                default:       mode_d = MODE_RUN;
            endcase
        end

        // Held at 0 outside RUN, so re-entering RUN gives a full tick period.
        presc_d = '0;
        if (mode_q == MODE_RUN && mode_d == MODE_RUN) begin
            presc_d = (presc_q == TC) ? '0 : presc_q + PW'(1);
        end
        tick_d = (mode_d == MODE_RUN) && (presc_d == TC);

        // A mode change in the same cycle drops the increment.
        inc_ok   = btn_inc && !btn_mode;
        sec_clr  = inc_ok && (mode_q == MODE_SET_MIN);
        min_inc  = sec_carry || sec_clr;
        hour_inc = (sec_carry && min_carry) || (inc_ok && mode_q == MODE_SET_HOUR);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q  <= MODE_RUN;
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    bcd_mod_counter #(.TENS_MAX(SEC_MAX_TENS), .UNITS_MAX(SEC_MAX_UNITS)) u_sec (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (tick_q),
        .clr   (sec_clr),
        .tens  (Second_First),
        .units (Second_Second),
        .carry (sec_carry)
    );

    bcd_mod_counter #(.TENS_MAX(MIN_MAX_TENS), .UNITS_MAX(MIN_MAX_UNITS)) u_min (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (min_inc),
        .clr   (1'b0),
        .tens  (Minute_First),
        .units (Minute_Second),
        .carry (min_carry)
    );

    bcd_mod_counter #(.TENS_MAX(HOUR_MAX_TENS), .UNITS_MAX(HOUR_MAX_UNITS)) u_hour (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hour_inc),
        .clr   (1'b0),
        .tens  (Hour_First),
        .units (Hour_Second),
        .carry (hour_carry_unused)
    );

    assign tick_1hz = tick_q;
    assign setting  = mode_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter with CLK_HZ=4: the reference keeps time of day as
// a seconds count and predicts every output for every cycle.
module tb_bcd_time_counter;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] hf, hs, mf, ms, sf, ss;
    logic       tick;
    logic [1:0] setting;

    int tests_run = 0;
    int tests_failed = 0;

    int m_mode = 0;
    int m_presc = 0;
    int m_tod = 0;
    bit m_tick = 1'b0;
    logic [26:0] exp_q[$];

    bcd_time_counter #(.CLK_HZ(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_mode      (btn_mode),
        .btn_inc       (btn_inc),
        .Hour_First    (hf),
        .Hour_Second   (hs),
        .Minute_First  (mf),
        .Minute_Second (ms),
        .Second_First  (sf),
        .Second_Second (ss),
        .tick_1hz      (tick),
        .setting       (setting)
    );

    always #5 clk = ~clk;

    function automatic logic [26:0] dut_vec();
        return {setting, tick, hf, hs, mf, ms, sf, ss};
    endfunction

    function automatic logic [26:0] time_vec(int mode, bit t, int h, int mi, int s);
        return {2'(mode), t, 4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10),
                4'(s / 10), 4'(s % 10)};
    endfunction

    // Reference: time of day as seconds since midnight, mode as 0/1/2.
    task automatic model_step(input bit m, input bit i, input bit r);
        int nm, np, h, mi;
        if (!r) begin
            m_mode = 0; m_presc = 0; m_tick = 1'b0; m_tod = 0;
        end else begin
            nm = m ? (m_mode + 1) % 3 : m_mode;
            if (m_tick) begin
                m_tod = (m_tod + 1) % 86400;
            end else if (i && !m && m_mode == 1) begin
                h = (m_tod / 3600 + 1) % 24;
                m_tod = h * 3600 + m_tod % 3600;
            end else if (i && !m && m_mode == 2) begin
                mi = ((m_tod / 60) % 60 + 1) % 60;
                m_tod = (m_tod / 3600) * 3600 + mi * 60;
            end
            np = (m_mode == 0 && nm == 0) ? (m_presc + 1) % N : 0;
            m_tick = (nm == 0) && (np == N - 1);
            m_mode = nm;
            m_presc = np;
        end
        exp_q.push_back(time_vec(m_mode, m_tick, m_tod / 3600, (m_tod / 60) % 60, m_tod % 60));
    endtask

    task automatic drive(input bit m, input bit i, input bit r);
        btn_mode = m;
        btn_inc  = i;
        rst_n    = r;
        @(posedge clk);
        model_step(m, i, r);
        #1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    task automatic test_reset();
        logic [26:0] e;
        int cyc, first_tick;
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0);
            e = exp_q.pop_front();
            tests_run++;
            if (dut_vec() !== e) begin
                tests_failed++;
                $display("FAIL reset_hold: got %h expected %h", dut_vec(), e);
            end
        end
        tests_run++;
        if (dut_vec() !== 27'd0) begin
            tests_failed++;
            $display("FAIL reset_values: got %h expected 0", dut_vec());
        end
        cyc = 1;
        first_tick = 0;
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 1);
            cyc++;
            e = exp_q.pop_front();
            tests_run++;
            if (dut_vec() !== e) begin
                tests_failed++;
                $display("FAIL reset_release cyc %0d: got %h expected %h", cyc, dut_vec(), e);
            end
            if (tick === 1'b1 && first_tick == 0) first_tick = cyc;
            if (cyc == 5) begin
                tests_run++;
                if (ss !== 4'd1) begin
                    tests_failed++;
                    $display("FAIL first_second: got %0d expected 1", ss);
                end
            end
        end
        tests_run++;
        if (first_tick !== 4) begin
            tests_failed++;
            $display("FAIL first_tick_cycle: got %0d expected 4", first_tick);
        end
    endtask

    task automatic test_minute_rollover();
        logic [26:0] e;
        drive(0, 0, 0);
        void'(exp_q.pop_front());
        for (int k = 1; k <= 60 * N; k++) begin
            drive(0, 0, 1);
            e = exp_q.pop_front();
            tests_run++;
            if (dut_vec() !== e || sf > 4'd5 || ss > 4'd9 || mf > 4'd5 || ms > 4'd9) begin
                tests_failed++;
                $display("FAIL minute_rollover cyc %0d: got %h expected %h", k, dut_vec(), e);
            end
        end
        tests_run++;
        if (dut_vec() !== time_vec(0, 0, 0, 1, 0)) begin
            tests_failed++;
            $display("FAIL minute_rollover_end: got %h expected %h", dut_vec(), time_vec(0, 0, 0, 1, 0));
        end
    endtask

    task automatic test_day_rollover();
        logic [26:0] e;
        bit m, i;
        drive(0, 0, 0);
        void'(exp_q.pop_front());
        // mode, 23 x inc, mode, 59 x inc, mode -> 23:59:00 in RUN
        for (int k = 0; k < 85; k++) begin
            m = (k == 0 || k == 24 || k == 84);
            i = !m;
            drive(m, i, 1);
            e = exp_q.pop_front();
            tests_run++;
            if (dut_vec() !== e) begin
                tests_failed++;
                $display("FAIL day_set step %0d: got %h expected %h", k, dut_vec(), e);
            end
        end
        for (int k = 1; k <= 60 * N; k++) begin
            drive(0, 0, 1);
            e = exp_q.pop_front();
            tests_run++;
            if (dut_vec() !== e) begin
                tests_failed++;
                $display("FAIL day_run cyc %0d: got %h expected %h", k, dut_vec(), e);
            end
            if (k == 59 * N || k == 60 * N - 1) begin
                tests_run++;
                if ({hf, hs, mf, ms, sf, ss} !== time_vec(0, 0, 23, 59, 59)) begin
                    tests_failed++;
                    $display("FAIL day_235959 cyc %0d: got %h", k, dut_vec());
                end
            end
        end
        tests_run++;
        if (dut_vec() !== time_vec(0, 0, 0, 0, 0)) begin
            tests_failed++;
            $display("FAIL day_rollover_end: got %h expected %h", dut_vec(), time_vec(0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_minute_set();
        logic [26:0] e;
        bit m, i;
        drive(0, 0, 0);
        void'(exp_q.pop_front());
        // mode, 5 x inc, mode, 59 x inc, mode, 37 s of run, mode, mode, inc
        for (int k = 0; k < 67 + 37 * N + 3; k++) begin
            m = (k == 0 || k == 6 || k == 66 || k == 67 + 37 * N || k == 68 + 37 * N);
            i = (k > 0 && k < 6) || (k > 6 && k < 66) || (k == 69 + 37 * N);
            drive(m, i, 1);
            e = exp_q.pop_front();
            tests_run++;
            if (dut_vec() !== e) begin
                tests_failed++;
                $display("FAIL minute_set step %0d: got %h expected %h", k, dut_vec(), e);
            end
            if (k == 66 + 37 * N) begin
                tests_run++;
                if (dut_vec() !== time_vec(0, 0, 5, 59, 37)) begin
                    tests_failed++;
                    $display("FAIL minute_set_pre: got %h expected %h", dut_vec(), time_vec(0, 0, 5, 59, 37));
                end
            end
            if (k >= 67 + 37 * N) begin
                tests_run++;
                if (tick !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL minute_set_tick step %0d: got %b expected 0", k, tick);
                end
            end
        end
        tests_run++;
        if (dut_vec() !== time_vec(2, 0, 5, 0, 0)) begin
            tests_failed++;
            $display("FAIL minute_set_wrap: got %h expected %h", dut_vec(), time_vec(2, 0, 5, 0, 0));
        end
    endtask

    task automatic test_simultaneous();
        logic [26:0] e;
        int cyc, first_tick;
        drive(0, 0, 0);
        void'(exp_q.pop_front());
        for (int k = 0; k < 6; k++) begin
            drive(k == 0 || k == 4 || k == 5, k != 0 && k != 5, 1);
            e = exp_q.pop_front();
            tests_run++;
            if (dut_vec() !== e) begin
                tests_failed++;
                $display("FAIL simultaneous step %0d: got %h expected %h", k, dut_vec(), e);
            end
            if (k == 4) begin
                tests_run++;
                if (setting !== 2'd2 || {hf, hs} !== {4'd0, 4'd3}) begin
                    tests_failed++;
                    $display("FAIL simultaneous_drop: got setting %0d hours %0d%0d expected 2 03", setting, hf, hs);
                end
            end
        end
        cyc = 1;
        first_tick = 0;
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 1);
            cyc++;
            e = exp_q.pop_front();
            tests_run++;
            if (dut_vec() !== e) begin
                tests_failed++;
                $display("FAIL resume_run cyc %0d: got %h expected %h", cyc, dut_vec(), e);
            end
            if (tick === 1'b1 && first_tick == 0) first_tick = cyc;
        end
        tests_run++;
        if (first_tick !== 4) begin
            tests_failed++;
            $display("FAIL resume_tick_cycle: got %0d expected 4", first_tick);
        end
    endtask

    task automatic test_reset_mid_set();
        logic [26:0] e;
        drive(0, 0, 0);
        void'(exp_q.pop_front());
        for (int k = 0; k < 16; k++) begin
            drive(k == 0, k != 0, 1);
            e = exp_q.pop_front();
            tests_run++;
            if (dut_vec() !== e) begin
                tests_failed++;
                $display("FAIL mid_set step %0d: got %h expected %h", k, dut_vec(), e);
            end
        end
        tests_run++;
        if (dut_vec() !== time_vec(1, 0, 15, 0, 0)) begin
            tests_failed++;
            $display("FAIL mid_set_hours: got %h expected %h", dut_vec(), time_vec(1, 0, 15, 0, 0));
        end
        drive(0, 1, 0);
        void'(exp_q.pop_front());
        tests_run++;
        if (dut_vec() !== 27'd0) begin
            tests_failed++;
            $display("FAIL mid_set_reset: got %h expected 0", dut_vec());
        end
    endtask

    task automatic test_random();
        logic [26:0] e;
        bit m, i, r;
        for (int k = 0; k < 1500; k++) begin
            r = ($urandom_range(0, 199) != 0);
            m = ($urandom_range(0, 29) == 0);
            i = ($urandom_range(0, 3) == 0);
            drive(m, i, r);
            e = exp_q.pop_front();
            tests_run++;
            if (dut_vec() !== e) begin
                tests_failed++;
                $display("FAIL random cyc %0d: got %h expected %h", k, dut_vec(), e);
            end
            tests_run++;
            if (hf > 4'd2 || (hf == 4'd2 && hs > 4'd3) || hs > 4'd9 || mf > 4'd5 ||
                ms > 4'd9 || sf > 4'd5 || ss > 4'd9) begin
                tests_failed++;
                $display("FAIL bcd_range cyc %0d: got %h expected all digits in range", k, dut_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_minute_rollover();
        test_day_rollover();
        test_minute_set();
        test_simultaneous();
        test_reset_mid_set();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bcd_time_counter.md
# bcd_time_counter

- Produces the hh:mm:ss time as BCD digits.
- Drives the `Minute_*`/`Second_*` digit bus read by the hourly chime block and the seven-segment display driver.
- Derives a 1 Hz tick from the system clock and advances a 24-hour time.
- Provides a button-driven set mode for hours and minutes.

## Interface
- `CLK_HZ`, default 100_000_000: system clock frequency. The prescaler terminal count is `CLK_HZ-1`. Benches override it to a small value.
- `clk` input 1: system clock, single clock domain.
- `rst_n` input 1: reset, synchronous and active-low.
- `btn_mode` input 1: one-cycle pulse, already debounced and edge-detected upstream. Advances the mode.
- `btn_inc` input 1: one-cycle pulse, already debounced. Increments the selected field in set modes.
- `Hour_First` output 4: hour tens, 0–2.
- `Hour_Second` output 4: hour units, 0–9.
- `Minute_First` output 4: minute tens, 0–5.
- `Minute_Second` output 4: minute units, 0–9.
- `Second_First` output 4: second tens, 0–5.
- `Second_Second` output 4: second units, 0–9.
- `tick_1hz` output 1: one-cycle pulse at prescaler terminal count, RUN mode only.
- `setting` output 2: current mode; 0 = RUN, 1 = SET_HOUR, 2 = SET_MIN.

## Operation
- **States:** RUN → SET_HOUR → SET_MIN → RUN. Each `btn_mode` pulse makes one transition.
- **Reset:**
  - State is RUN and the prescaler is 0.
  - All digit outputs are 0, so the time reads 00:00:00.
  - `tick_1hz` is 0 and `setting` is 0.
- **RUN mode, per tick:**
  - Seconds increment 00..59. At 59 they wrap to 00 and carry into minutes.
  - Minutes increment 00..59. At 59 with a carry they wrap to 00 and carry into hours.
  - Hours increment 00..23 and wrap 23 → 00.
  - A full ripple happens in a single cycle, e.g. 23:59:59 → 00:00:00.
- **SET_HOUR mode:**
  - Prescaler is held at 0, no ticks are issued, seconds are frozen.
  - `btn_inc` increments hours 00..23 with wrap and no carry.
- **SET_MIN mode:**
  - Prescaler is held at 0 and no ticks are issued.
  - `btn_inc` increments minutes 00..59 with wrap, no carry into hours, and clears seconds to 00.
- **Leaving SET_MIN for RUN:** prescaler restarts from 0, so the first tick comes `CLK_HZ` cycles after the transition.
- `btn_inc` in RUN is ignored.
- **Simultaneous `btn_mode` and `btn_inc`:** the mode change wins and the increment is dropped.
- **Digit validity:** every digit is valid BCD at all times. Units only ever reach 9 and tens only their field limit; no out-of-range value is ever driven. Each field is held as a tens/units pair; there is no binary-to-BCD conversion.

## Timing
- All outputs are registered.
- **Prescaler:** counts 0..`CLK_HZ-1`.
  - On the cycle it equals `CLK_HZ-1` in RUN: `tick_1hz` is high that cycle, and the digits show the new value from the next cycle.
  - It then returns to 0, giving a tick period of exactly `CLK_HZ` cycles.
- **`btn_inc` latency:** the incremented field is visible 1 cycle after the pulse.
- **`btn_mode` latency:** `setting` changes 1 cycle after the pulse.
- **Reset mid-operation:** `rst_n` low on any edge forces the reset values on that edge, with priority over ticks and buttons. Counting resumes from 0 on the first edge with `rst_n` high.
- **Downstream guarantee:** each digit combination is held for a whole tick period in RUN. The chime block therefore sees 59:5x and 00:00 for full seconds.

## Structure
- **Shared package `clock_pkg`:**
  - Mode encoding `MODE_RUN`, `MODE_SET_HOUR`, `MODE_SET_MIN`.
  - BCD limit constants `SEC_MAX`/`MIN_MAX` = 5,9 and `HOUR_MAX` = 2,3.
  - The 4-bit digit type.
  The chime block and display driver import the same package.
- **Sub-module `bcd_mod_counter`:**
  - Two-digit BCD counter with parameters for tens/units limit.
  - Inputs `inc` and `clr`; outputs the digit pair and a combinational `carry` (asserted when `inc` fires at the limit).
  - Instantiated three times: seconds, minutes, hours.
- The top level holds the prescaler, mode FSM and increment steering.

## Test plan
All cases use `CLK_HZ=4`.
- **Reset:** hold `rst_n`=0 for 3 cycles → all digits 0, `setting`=0, `tick_1hz`=0. Release → first `tick_1hz` at cycle 4, `Second_Second`=1 on the following cycle.
- **Minute rollover:** run from 00:00:58 → after 2 ticks reads 00:01:00, with the rollover in one cycle and no intermediate 00:00:60 or 00:01:60 visible.
- **Day rollover:** set 23:59:59 → next tick gives 00:00:00 in one cycle.
- **Minute set:** `btn_mode` ×2 to SET_MIN with minutes at 59 and seconds 37 → `btn_inc` gives minutes 00, seconds 00, hours unchanged, and `tick_1hz` stays 0 throughout.
- **Simultaneous buttons:** `btn_mode` and `btn_inc` in the same cycle in SET_HOUR → `setting`=2 and hours unchanged. Another `btn_mode` → RUN, with the next tick exactly 4 cycles later.
- **Reset mid-set:** `rst_n` low while in SET_HOUR at hours 15 → next cycle `setting`=0 and all digits 0.
